// File: rtl/program_counter_if.sv
// program_counter_if: next-PC select/target in, current_PC and PC_Plus_4 out; master drives select/target, slave drives addresses
interface program_counter_if #(parameter int WIDTH = 32);
  logic             PCSrc;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] current_PC;
  logic [WIDTH-1:0] PC_Plus_4;
  modport master(output PCSrc, Result, input current_PC, PC_Plus_4);
  modport slave(input PCSrc, Result, output current_PC, PC_Plus_4);
endinterface

// File: rtl/program_counter.sv
// program_counter: PC register (CLK, sync active-high Reset; pc.slave: PCSrc/Result in, current_PC/PC_Plus_4 out) loading Result or current_PC+INCREMENT
module program_counter #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INCREMENT    = 4
) (
  input logic              CLK,
  input logic              Reset,
  program_counter_if.slave pc
);
  assign pc.PC_Plus_4 = pc.current_PC + WIDTH'(INCREMENT);
  always_ff @(posedge CLK)
    pc.current_PC <= Reset ? RESET_VECTOR : pc.PCSrc ? pc.Result : pc.PC_Plus_4;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vector table, asynchronous-glitch sequence and randomized run against a reference model
module tb_program_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  program_counter_if #(.WIDTH(32)) pif();
  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0), .INCREMENT(4)) dut (
    .CLK(clk),
    .Reset(rst),
    .pc(pif)
  );

  typedef struct {
    bit          r;
    bit          s;
    logic [31:0] res;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit s, input logic [31:0] res);
    rst = r;
    pif.PCSrc = s;
    pif.Result = res;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    pif.PCSrc = 1'b0;
    pif.Result = 32'h1;
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 32'h1, 32'h0, 32'h4});
    tbl.push_back('{0, 0, 32'h1, 32'h4, 32'h8});
    tbl.push_back('{0, 0, 32'h1, 32'h8, 32'hC});
    tbl.push_back('{0, 0, 32'h1, 32'hC, 32'h10});
    tbl.push_back('{0, 1, 32'h7, 32'h7, 32'hB});
    tbl.push_back('{0, 1, 32'h8, 32'h8, 32'hC});
    tbl.push_back('{0, 1, 32'h9, 32'h9, 32'hD});
    tbl.push_back('{0, 1, 32'hA, 32'hA, 32'hE});
    tbl.push_back('{0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0});
    tbl.push_back('{0, 0, 32'h0, 32'h0, 32'h4});
    tbl.push_back('{0, 0, 32'h0, 32'h4, 32'h8});
    tbl.push_back('{1, 1, 32'h55, 32'h0, 32'h4});
    tbl.push_back('{0, 1, 32'h3, 32'h3, 32'h7});
    tbl.push_back('{0, 0, 32'h0, 32'h7, 32'hB});
    tbl.push_back('{1, 0, 32'h0, 32'h0, 32'h4});
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].res);
      chk($sformatf("vec%0d_pc", i), pif.current_PC, tbl[i].e_pc);
      chk($sformatf("vec%0d_p4", i), pif.PC_Plus_4, tbl[i].e_p4);
    end
    drive(0, 1, 32'h100);
    chk("pre_glitch_pc", pif.current_PC, 32'h100);
    #2;
    rst = 1'b1;
    pif.PCSrc = 1'b1;
    pif.Result = 32'h123;
    #2;
    chk("glitch_hold_pc", pif.current_PC, 32'h100);
    chk("glitch_hold_p4", pif.PC_Plus_4, 32'h104);
    rst = 1'b0;
    pif.PCSrc = 1'b0;
    drive(0, 0, 32'h0);
    chk("post_glitch_pc", pif.current_PC, 32'h104);
    for (int i = 0; i < 3; i++) begin
      drive(1, i[0], 32'hDEAD_BEEF);
      chk($sformatf("hold_rst%0d_pc", i), pif.current_PC, 32'h0);
    end
    drive(0, 0, 32'h0);
    chk("after_rst_pc", pif.current_PC, 32'h4);
    m_pc = 32'h4;
    for (int i = 0; i < 300; i++) begin
      bit          r, s;
      logic [31:0] res;
      r = ($urandom_range(15) == 0);
      s = ($urandom_range(2) == 0);
      res = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
      m_pc = r ? 32'h0 : s ? res : 32'(64'(m_pc) + 64'd4);
      drive(r, s, res);
      chk($sformatf("rnd%0d_pc", i), pif.current_PC, m_pc);
      chk($sformatf("rnd%0d_p4", i), pif.PC_Plus_4, 32'(64'(m_pc) + 64'd4));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
